// File: rtl/id_stage_pkg.sv
// Shared pipeline constants for the decode stage: opcodes, funct codes, reset PC
// and a small hazard-match helper.
package id_stage_pkg;

  localparam logic [31:0] RESET_PC4 = 32'h0000_3004;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    ExtSign,
    ExtZero,
    ExtHigh
  } ext_mode_e;

  // True when an enabled producer writing wa will overwrite source register r.
  function automatic logic dep_hit(logic [4:0] r, logic en, logic [4:0] wa);
    return en && (r != 5'd0) && (wa == r);
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register $0 hardwired to zero.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file with MEM/WB forwarding, immediate
// extension, hazard stall generation and branch/jump redirect.
module id_stage #(
  parameter logic [31:0] RESET_PC4 = id_stage_pkg::RESET_PC4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_F,
  input  logic [31:0] PC4_F,
  input  logic        RegWrite_W,
  input  logic [4:0]  WA_W,
  input  logic [31:0] WD_W,
  input  logic        RegWrite_M,
  input  logic        MemRead_M,
  input  logic [4:0]  WA_M,
  input  logic [31:0] WD_M,
  input  logic        RegWrite_E,
  input  logic        MemRead_E,
  input  logic [4:0]  WA_E,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] Npc,
  output logic [31:0] IR_D,
  output logic [31:0] PC4_D,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] Ext32
);

  import id_stage_pkg::*;

  logic [31:0] ir_q, pc4_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;

  logic        is_beq, is_bne, is_br, is_j, is_jal, is_jr;
  logic        reads_rs, reads_rt;
  logic        fwd_m;
  logic        load_use, br_hazard, taken;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] br_target, jmp_target;
  ext_mode_e   ext_mode;

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q  <= '0;
      pc4_q <= RESET_PC4;
    end else if (!Stall) begin
      ir_q  <= IR_F;
      pc4_q <= PC4_F;
    end
  end

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign imm   = ir_q[15:0];
  assign funct = ir_q[5:0];

  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_br  = is_beq || is_bne;
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_jr  = (op == OP_RTYPE) && (funct == FUNCT_JR);

  // Jumps and lui carry no rs operand; only R-type, branches and stores read rt.
  assign reads_rs = !(is_j || is_jal || (op == OP_LUI));
  assign reads_rt = (op == OP_RTYPE) || is_br || (op == OP_SW);

  reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .we    (RegWrite_W),
    .wa    (WA_W),
    .wd    (WD_W),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // A load in MEM has no data yet, so only ALU results are forwarded from there.
  assign fwd_m = RegWrite_M && !MemRead_M;

  always_comb begin
    RD1 = rf_rd1;
    if (rs == 5'd0) begin
      RD1 = '0;
    end else if (fwd_m && (WA_M == rs)) begin
      RD1 = WD_M;
    end else if (RegWrite_W && (WA_W == rs)) begin
      RD1 = WD_W;
    end
  end

  always_comb begin
    RD2 = rf_rd2;
    if (rt == 5'd0) begin
      RD2 = '0;
    end else if (fwd_m && (WA_M == rt)) begin
      RD2 = WD_M;
    end else if (RegWrite_W && (WA_W == rt)) begin
      RD2 = WD_W;
    end
  end

  always_comb begin
    ext_mode = ExtSign;
    if ((op == OP_ORI) || (op == OP_ANDI)) begin
      ext_mode = ExtZero;
    end else if (op == OP_LUI) begin
      ext_mode = ExtHigh;
    end
  end

  always_comb begin
    Ext32 = {{16{imm[15]}}, imm};
    unique case (ext_mode)
      ExtZero: Ext32 = {16'h0000, imm};
      ExtHigh: Ext32 = {imm, 16'h0000};
      default: Ext32 = {{16{imm[15]}}, imm};
    endcase
  end

  assign load_use = dep_hit(rs, MemRead_E && reads_rs, WA_E)
                 || dep_hit(rt, MemRead_E && reads_rt, WA_E);

  // Branch compares happen here, so any value still in flight in EX, or a load in
  // MEM, must arrive before the compare can be trusted.
  assign br_hazard = ((is_br || is_jr)
                       && (dep_hit(rs, RegWrite_E, WA_E) || dep_hit(rs, MemRead_M, WA_M)))
                  || (is_br
                       && (dep_hit(rt, RegWrite_E, WA_E) || dep_hit(rt, MemRead_M, WA_M)));

  assign Stall = load_use || br_hazard;

  assign taken = (is_beq && (RD1 == RD2)) || (is_bne && (RD1 != RD2))
              || is_j || is_jal || is_jr;
  assign PCSrc = taken && !Stall;

  assign br_target  = pc4_q + {{14{imm[15]}}, imm, 2'b00};
  assign jmp_target = {pc4_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    Npc = br_target;
    if (is_jr) begin
      Npc = RD1;
    end else if (is_j || is_jal) begin
      Npc = jmp_target;
    end
  end

  // A stalled instruction is held here and a bubble goes on to EX.
  assign IR_D  = Stall ? '0 : ir_q;
  assign PC4_D = pc4_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter RESET_PC4, default 32'h0000_3004, SHALL be the PC4_D value after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high.
REQ-004 IR_F  input  32  SHALL be the instruction from the fetch stage.
REQ-005 PC4_F  input  32  SHALL be fetch PC+4.
REQ-006 RegWrite_W  input  1  SHALL be the writeback enable.
REQ-007 WA_W  input  5  SHALL be the writeback register number.
REQ-008 WD_W  input  32  SHALL be the writeback data.
REQ-009 RegWrite_M  input  1  SHALL flag a register-writing instruction in MEM.
REQ-010 MemRead_M  input  1  SHALL flag a load in MEM.
REQ-011 WA_M  input  5  SHALL be the MEM destination register.
REQ-012 WD_M  input  32  SHALL be the MEM ALU result (valid only when MemRead_M=0).
REQ-013 RegWrite_E  input  1  SHALL flag a register-writing instruction in EX.
REQ-014 MemRead_E  input  1  SHALL flag a load in EX.
REQ-015 WA_E  input  5  SHALL be the EX destination register.
REQ-016 Stall  output  1  SHALL freeze fetch PC and this stage's IF/ID register.
REQ-017 PCSrc  output  1  SHALL select Npc in the fetch stage.
REQ-018 Npc  output  32  SHALL be the redirect target.
REQ-019 IR_D  output  32  SHALL be the decoded instruction, forced to 0 (NOP) toward EX while Stall=1.
REQ-020 PC4_D  output  32  SHALL be the latched PC+4 of IR_D.
REQ-021 RD1, RD2  output  32 each  SHALL be forwarded rs/rt values.
REQ-022 Ext32  output  32  SHALL be the extended immediate.

Function
REQ-023 IF/ID register SHALL load IR_F/PC4_F each rising edge when Stall=0 and hold when Stall=1.
REQ-024 Register file: 32x32; write on rising edge when RegWrite_W=1 and WA_W!=0; $0 SHALL always read 0.
REQ-025 Operand mux priority per rs/rt: reg 0 -> 0; RegWrite_M & !MemRead_M & WA_M match -> WD_M; RegWrite_W & WA_W match -> WD_W (same-cycle bypass); else register file.
REQ-026 Ext32: zero-extend for ori/andi; {imm,16'h0} for lui; sign-extend otherwise.
REQ-027 Stall=1 on load-use: MemRead_E & WA_E!=0 & WA_E equals an rs/rt read by IR_D.
REQ-028 Stall=1 when beq/bne/jr in D reads a nonzero register matching WA_E with RegWrite_E=1, or matching WA_M with MemRead_M=1.
REQ-029 Stall SHALL be purely combinational; no stall counter; it deasserts as soon as the hazard leaves.
REQ-030 PCSrc=1 for taken beq (000100, equal) / bne (000101, unequal), j (000010), jal (000011), jr (R-type funct 001000); PCSrc SHALL be 0 whenever Stall=1.
REQ-031 Npc: branch = PC4_D + (signext(imm)<<2), mod 2^32; j/jal = {PC4_D[31:28], IR_D[25:0], 2'b00}; jr = forwarded rs.
REQ-032 Delay slot: the instruction in fetch when PCSrc=1 SHALL enter IF/ID normally; no flush.

Reset
REQ-033 Reset SHALL clear IR_D to 0, set PC4_D to RESET_PC4, and clear all 32 registers, asynchronously, including mid-stall.
REQ-034 During reset Stall=0, PCSrc=0, RD1=RD2=0.

Structure
REQ-035 Opcode/funct constants and RESET_PC4 SHALL live in the shared pipeline constants package.
REQ-036 Register file SHALL be sub-module reg_file (2 read, 1 write, $0 hardwired).

Verification
REQ-037 Reset asserted mid-stall -> IR_D=0, PC4_D=0x3004, Stall=0, PCSrc=0, all registers read 0.
REQ-038 W writes $8=0x1234; same-cycle read rs=8 -> RD1=0x1234; write to $0 -> reads stay 0.
REQ-039 MemRead_E=1, WA_E=8, IR_D=addu $9,$8,$10 -> Stall=1, IR_D held, EX sees 0; next cycle MemRead_E=0 -> Stall=0.
REQ-040 beq $1,$2, imm=0xFFFF, PC4_D=0x3008, WD_M=5 for $1, $2=5 in RF -> PCSrc=1, Npc=0x3004.
REQ-041 jr $31 with $31=0x3020 -> Npc=0x3020; jal index 0x0000C04, PC4_D=0x3008 -> Npc=0x3010.
REQ-042 beq reading $4 with RegWrite_E=1, WA_E=4 -> Stall=1, PCSrc=0 until the producer reaches MEM.
